wb_arbiter2: RTL
================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles a strobe may wait for ack before error; range 0..255; 0 disables timeout.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 gives M0 absolute priority.
REQ-003 sys_clk  input  1  single clock for the whole block.
REQ-004 sys_rstn  input  1  reset, asynchronous, active-low.
REQ-005 m0_adr_i, m0_dat_i  input  32 each  M0 (CPU) address and write data.
REQ-006 m0_sel_i  input  4  M0 byte select.
REQ-007 m0_we_i, m0_stb_i, m0_cyc_i  input  1 each  M0 write enable, strobe, cycle.
REQ-008 m0_dat_o  output  32  M0 read data.
REQ-009 m0_ack_o, m0_err_o  output  1 each  M0 acknowledge and timeout error.
REQ-010 m1_* ports  same directions and widths as m0_*  M1 (DMA) master.
REQ-011 s_adr_o, s_dat_o  output  32 each  shared-bus address and write data.
REQ-012 s_sel_o  output  4  shared-bus byte select.
REQ-013 s_we_o, s_stb_o, s_cyc_o  output  1 each  shared-bus controls.
REQ-014 s_dat_i  input  32  read data from the decoded slave.
REQ-015 s_ack_i  input  1  ack from the decoded slave.
REQ-016 gnt_o  output  2  one-hot grant: bit0 M0, bit1 M1, 00 idle.

Function
REQ-017 FSM states IDLE, BUS0, BUS1, registered on sys_clk.
REQ-018 IDLE, exactly one mN_cyc_i high: next state BUSn.
REQ-019 IDLE, both cyc high, FIXED_PRIO=1: next state BUS0.
REQ-020 IDLE, both cyc high, FIXED_PRIO=0: grant the master not in last_gnt.
REQ-021 last_gnt: 1-bit register, set to the granted index on each IDLE->BUSn transition.
REQ-022 IDLE, neither cyc high: stay in IDLE.
REQ-023 Grant latency: cyc rising in IDLE at cycle n -> BUSn and s_cyc_o/s_stb_o visible at n+1.
REQ-024 BUSn: s_adr/dat/sel/we/stb/cyc_o driven combinationally from master n.
REQ-025 IDLE: s_cyc_o=0, s_stb_o=0, s_we_o=0; s_adr_o, s_dat_o, s_sel_o driven 0.
REQ-026 m0_dat_o and m1_dat_o both carry s_dat_i unconditionally.
REQ-027 BUSn: mN_ack_o = s_ack_i; the non-granted master's ack and err are 0.
REQ-028 BUSn, mN_cyc_i low: next state IDLE, guaranteeing at least one s_cyc_o-low cycle between tenures.
REQ-029 Tenure: the granted master keeps the bus across multiple strobes while its cyc stays high; no preemption.
REQ-030 Timeout counter, 8 bits: increments each cycle s_stb_o=1 and s_ack_i=0; clears on ack, on stb low, and in IDLE.
REQ-031 Counter reaching TIMEOUT-1 with no ack: pulse mN_err_o one cycle and clear the counter; state unchanged.
REQ-032 Ack and timeout in the same cycle: ack wins, err stays 0.
REQ-033 TIMEOUT=0: err never asserted; the counter may hold 0.
REQ-034 gnt_o = 01 in BUS0, 10 in BUS1, 00 in IDLE.

Reset
REQ-035 sys_rstn low: immediately force state=IDLE, last_gnt=1 (M0 wins the first contested grant), counter=0.
REQ-036 Outputs during reset: all acks, errs, s_cyc_o, s_stb_o and gnt_o are 0.
REQ-037 Reset asserted mid-tenure: abort the tenure with no ack/err pulse.
REQ-038 First grant after reset release: no earlier than the first sys_clk edge with sys_rstn high.

Verification
REQ-039 Solo: M0 cyc/stb at cycle 0, slave acks at cycle 3 -> gnt_o=01 from cycle 1, m0_ack_o=1 at cycle 3, m1_ack_o=0 throughout.
REQ-040 Contention, round-robin: both cyc held high -> grant order M0, M1, M0, M1, with one s_cyc_o=0 cycle between tenures.
REQ-041 FIXED_PRIO=1, both always requesting: M0 granted every tenure; M1 granted only when M0 cyc is low in IDLE.
REQ-042 TIMEOUT=8, slave never acks: m0_err_o=1 for exactly one cycle at the 8th strobe cycle; M0 drops cyc -> IDLE next cycle.
REQ-043 TIMEOUT=8, ack on the 8th stall cycle: m0_ack_o=1, m0_err_o=0.
REQ-044 sys_rstn pulsed low during a BUS1 tenure -> s_cyc_o=0 at once; after release with both requesting, M0 is granted first.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master Wibone arbiter: M0 (CPU) and M1 (DMA) share one slave bus.
// A master holds the bus for as long as its cyc stays high; stalled strobes time out with a one-cycle err.
module wb_arbiter2 #(
    parameter int TIMEOUT    = 255,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT > 0);
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       to_hit;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // last_gnt_q holds the index of the most recent grant; a contested
    // round-robin request goes to the other master.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (FIXED_PRIO || last_gnt_q) begin
                        state_d    = BUS0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d    = BUS1;
                        last_gnt_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d    = BUS0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = BUS1;
                    last_gnt_d = 1'b1;
                end
            end
            BUS0:    if (!m0_cyc_i) state_d = IDLE;
            BUS1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_sel_o = 4'd0;
        s_we_o  = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        gnt_o   = 2'b00;
        case (state_q)
            BUS0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_stb_o = m0_stb_i;
                s_cyc_o = m0_cyc_i;
                gnt_o   = 2'b01;
            end
            BUS1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_stb_o = m1_stb_i;
                s_cyc_o = m1_cyc_i;
                gnt_o   = 2'b10;
            end
            default: ;
        endcase
    end

    // Handshake: a transfer completes in any cycle where s_stb_o and s_ack_i are both high;
    // the master keeps stb and its request stable until then. An ack always beats a timeout.
    assign to_hit = TO_EN && s_stb_o && !s_ack_i && (cnt_q == TO_LAST);

    always_comb begin
        if (!TO_EN || state_q == IDLE || !s_stb_o || s_ack_i || to_hit) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            BUS0: begin
                m0_ack_o = s_ack_i;
                m0_err_o = to_hit;
            end
            BUS1: begin
                m1_ack_o = s_ack_i;
                m1_err_o = to_hit;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
